// File: rtl/serial_bus_arbiter_pkg.sv
// Shared types and default sizing for the serial bus arbiter, bus mux and masters.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_GAP
  } arb_state_t;

  localparam int DEF_N_MASTERS  = 4;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_HOLD_MAX   = 50000;

endpackage

// File: rtl/serial_bus_arbiter_picker.sv
// Round-robin priority picker: first eligible index after last_owner, wrapping.
module rr_priority_picker #(
  parameter int N_MASTERS = 4,
  parameter int IW        = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] eligible,
  input  logic [IW-1:0]        last_owner,
  output logic                 found,
  output logic [IW-1:0]        winner
);

  // Scan from the farthest offset down so the nearest eligible index wins last.
  always_comb begin
    int          t;
    logic [IW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    t      = 0;
    idx    = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      t   = (int'(last_owner) + k) % N_MASTERS;
      idx = IW'(t);
      if (eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with turnaround gap between owners.
// Optional hold watchdog compiled in with `define ARB_TIMEOUT_EN.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int N_MASTERS  = DEF_N_MASTERS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int HOLD_MAX   = DEF_HOLD_MAX
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [N_MASTERS-1:0]         req,
  output logic [N_MASTERS-1:0]         grant,
  output logic [$clog2(N_MASTERS)-1:0] bus_sel,
  output logic                         bus_busy,
  output logic                         timeout_err,
  output logic [$clog2(N_MASTERS)-1:0] timeout_id
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (N_MASTERS < 2 || N_MASTERS > 16 || GAP_CYCLES < 1 || HOLD_MAX < 2) begin : g_param_err
    $error("serial_bus_arbiter: illegal parameter combination");
  end

  arb_state_t          state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic [IW-1:0]        last_q, last_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [N_MASTERS-1:0] eligible;
  logic                 found;
  logic [IW-1:0]        winner;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX);
  logic [HW-1:0]        hold_q, hold_d;
  logic [N_MASTERS-1:0] mask_q, mask_d;
  logic                 terr_q, terr_d;
  logic [IW-1:0]        tid_q, tid_d;

  assign eligible    = req & ~mask_q;
  assign timeout_err = terr_q;
  assign timeout_id  = tid_q;
`else
  assign eligible    = req;
  assign timeout_err = 1'b0;
  assign timeout_id  = '0;
`endif

  rr_priority_picker #(.N_MASTERS(N_MASTERS), .IW(IW)) u_pick (
    .eligible   (eligible),
    .last_owner (last_q),
    .found      (found),
    .winner     (winner)
  );

  // Next-state and registered-output computation for IDLE -> GRANT -> GAP -> IDLE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    gap_d   = gap_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    mask_d  = mask_q & req;  // a revoked master is re-enabled once it lets go
    terr_d  = 1'b0;
    tid_d   = tid_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          sel_d           = winner;
          busy_d          = 1'b1;
          state_d         = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d          = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!req[sel_q]) begin
          grant_d = '0;
          sel_d   = '0;
          busy_d  = 1'b0;
          last_d  = sel_q;
          gap_d   = '0;
          state_d = ARB_GAP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HW'(HOLD_MAX - 1)) begin
          grant_d       = '0;
          sel_d         = '0;
          busy_d        = 1'b0;
          last_d        = sel_q;
          gap_d         = '0;
          state_d       = ARB_GAP;
          terr_d        = 1'b1;
          tid_d         = sel_q;
          mask_d[sel_q] = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      ARB_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = ARB_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers; reset drops any grant immediately with no gap.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= IW'(N_MASTERS - 1);
      gap_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      mask_q  <= '0;
      terr_q  <= 1'b0;
      tid_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      terr_q  <= terr_d;
      tid_q   <= tid_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign bus_sel  = sel_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter (N_MASTERS=4, GAP_CYCLES=2, HOLD_MAX=100).
module tb_serial_bus_arbiter;

  localparam int GAP = 2;

  logic       clk;
  logic       rstN;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] bus_sel;
  logic       bus_busy;
  logic       timeout_err;
  logic [1:0] timeout_id;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  serial_bus_arbiter #(.N_MASTERS(4), .GAP_CYCLES(GAP), .HOLD_MAX(100)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .req         (req),
    .grant       (grant),
    .bus_sel     (bus_sel),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] s, input logic b);
    vec_t v;
    v.rstn = r; v.req = rq; v.grant = g; v.sel = s; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic r, input logic [3:0] rq);
    rstN = r;
    req  = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    rstN = 1'b1;
  endtask

  // Structural invariants sampled mid-cycle throughout the run.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] e;
      e = 4'b0001 << bus_sel;
      total++;
      if (!$onehot0(grant) || (grant != 4'b0 && grant != e) ||
          (grant == 4'b0 && bus_sel != 2'd0) || bus_busy != (|grant)) begin
        bad++;
        $display("FAIL invariant: grant=%b bus_sel=%0d bus_busy=%b", grant, bus_sel, bus_busy);
      end
    end
  end

  initial begin
    int cnt;
    bit ok;
    logic [3:0] rq;
    rstN = 1'b0;
    req  = 4'b0;

    // Reset hold with all requests, single master, contention, reset mid-grant.
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(1, 4'b0100, 4'b0100, 2, 1);
    add(1, 4'b0100, 4'b0100, 2, 1);
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0100, 4'b0000, 0, 0);
    add(1, 4'b0100, 4'b0000, 0, 0);
    add(1, 4'b0100, 4'b0100, 2, 1);
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0010, 4'b0010, 1, 1);
    add(1, 4'b0011, 4'b0010, 1, 1);
    add(1, 4'b1001, 4'b0000, 0, 0);
    add(1, 4'b1001, 4'b0000, 0, 0);
    add(1, 4'b1001, 4'b0000, 0, 0);
    add(1, 4'b1001, 4'b1000, 3, 1);
    add(0, 4'b1000, 4'b0000, 0, 0);
    add(1, 4'b1000, 4'b1000, 3, 1);
    add(0, 4'b1111, 4'b0000, 0, 0);
    add(1, 4'b1111, 4'b0001, 0, 1);

    step(1'b0, 4'b0000);
    mon_en = 1'b1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);
    chk("reset_timeout_id", int'(timeout_id), 0);

    foreach (vq[i]) begin
      step(vq[i].rstn, vq[i].req);
      chk($sformatf("vec%0d_grant", i), int'(grant), int'(vq[i].grant));
      chk($sformatf("vec%0d_sel", i), int'(bus_sel), int'(vq[i].sel));
      chk($sformatf("vec%0d_busy", i), int'(bus_busy), int'(vq[i].busy));
      chk($sformatf("vec%0d_terr", i), int'(timeout_err), 0);
    end

    // Round robin with all masters requesting: order 0,1,2,3,0.
    do_reset();
    step(1'b1, 4'b1111);
    for (int o = 0; o < 5; o++) begin
      chk($sformatf("rr%0d_grant", o), int'(grant), 1 << (o % 4));
      chk($sformatf("rr%0d_sel", o), int'(bus_sel), o % 4);
      ok = 1'b1;
      for (int c = 0; c < 9; c++) begin
        step(1'b1, 4'b1111);
        if (grant != (4'b0001 << (o % 4))) ok = 1'b0;
      end
      chk($sformatf("rr%0d_hold", o), int'(ok), 1);
      rq = 4'b1111;
      rq[o % 4] = 1'b0;
      step(1'b1, rq);
      chk($sformatf("rr%0d_release", o), int'(grant), 0);
      if (o < 4) begin
        step(1'b1, 4'b1111);
        cnt = 1;
        while (grant == 4'b0 && cnt < 20) begin
          step(1'b1, 4'b1111);
          cnt++;
        end
        chk($sformatf("rr%0d_gap", o), cnt, GAP + 1);
      end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog: master 0 stuck, master 2 waiting.
    do_reset();
    step(1'b1, 4'b0101);
    cnt = 0;
    while (grant == 4'b0001 && cnt < 200) begin
      cnt++;
      step(1'b1, 4'b0101);
    end
    chk("to_hold_cycles", cnt, 100);
    chk("to_err_pulse", int'(timeout_err), 1);
    chk("to_id", int'(timeout_id), 0);
    step(1'b1, 4'b0101);
    chk("to_err_clear", int'(timeout_err), 0);
    step(1'b1, 4'b0101);
    step(1'b1, 4'b0101);
    chk("to_next_grant", int'(grant), 4'b0100);
    step(1'b1, 4'b0001);
    chk("to_release2", int'(grant), 0);
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 4'b0001);
      if (grant != 4'b0) ok = 1'b0;
    end
    chk("to_masked", int'(ok), 1);
    chk("to_id_holds", int'(timeout_id), 0);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    chk("to_unmask_grant", int'(grant), 4'b0001);
`else
    // No watchdog: a grant is held as long as the request stays high.
    do_reset();
    step(1'b1, 4'b0101);
    chk("hold_first", int'(grant), 4'b0001);
    ok = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      step(1'b1, 4'b0101);
      if (grant != 4'b0001 || timeout_err != 1'b0) ok = 1'b0;
    end
    chk("hold_10000", int'(ok), 1);
    step(1'b1, 4'b0100);
    chk("hold_release", int'(grant), 0);
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
